// File: rtl/serial_display_receiver.sv
// Serial display-controller receiver: synchronizes an asynchronous 3-wire
// serial link, assembles 16-bit address/data words and decodes them into
// digit and control registers. Optional macro SERIAL_RX_FRAME_CHECK_EN
// rejects frames whose bit count is not exactly 16.
module serial_display_receiver (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_serial_din,
    input  logic       i_serial_clk,
    input  logic       i_serial_load,
    input  logic [2:0] i_rd_addr,
    output logic [7:0] o_rd_data,
    output logic [7:0] o_decode_mode,
    output logic [3:0] o_intensity,
    output logic [2:0] o_scan_limit,
    output logic       o_shutdown_n,
    output logic       o_display_test,
    output logic       o_word_valid,
    output logic [15:0] o_word,
    output logic       o_frame_err
);

    logic [1:0]      din_sync;
    logic [1:0]      sclk_sync;
    logic [1:0]      load_sync;
    logic            sclk_hist;
    logic            load_hist;
    logic            clk_rise;
    logic            load_rise;
    logic [15:0]     shreg;
    logic [15:0]     shift_next;
    logic [4:0]      bit_cnt;
    logic [4:0]      cnt_next;
    logic            commit;
    logic [3:0]      addr;
    logic [7:0]      data;
    logic [2:0]      digit_idx;
    logic [7:0][7:0] digits;

    // History flops reset low, so a line already high at release gives one edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            din_sync  <= '0;
            sclk_sync <= '0;
            load_sync <= '0;
            sclk_hist <= 1'b0;
            load_hist <= 1'b0;
        end else begin
            din_sync  <= {din_sync[0], i_serial_din};
            sclk_sync <= {sclk_sync[0], i_serial_clk};
            load_sync <= {load_sync[0], i_serial_load};
            sclk_hist <= sclk_sync[1];
            load_hist <= load_sync[1];
        end
    end

    assign clk_rise  = sclk_sync[1] & ~sclk_hist;
    assign load_rise = load_sync[1] & ~load_hist;

    // Post-shift view: a load edge coinciding with a clock edge sees the new bit.
    assign shift_next = clk_rise ? {shreg[14:0], din_sync[1]} : shreg;
    assign cnt_next   = (clk_rise && bit_cnt != 5'd31) ? bit_cnt + 5'd1 : bit_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            shreg   <= shift_next;
            bit_cnt <= load_rise ? 5'd0 : cnt_next;
        end
    end

`ifdef SERIAL_RX_FRAME_CHECK_EN
    assign commit = load_rise && (cnt_next == 5'd16);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) o_frame_err <= 1'b0;
        else            o_frame_err <= load_rise && (cnt_next != 5'd16);
    end
`else
    assign commit      = load_rise;
    assign o_frame_err = 1'b0;
`endif

    assign addr      = shift_next[11:8];
    assign data      = shift_next[7:0];
    assign digit_idx = 3'(addr - 4'd1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_word         <= '0;
            o_word_valid   <= 1'b0;
            digits         <= '0;
            o_decode_mode  <= '0;
            o_intensity    <= '0;
            o_scan_limit   <= '0;
            o_shutdown_n   <= 1'b0;
            o_display_test <= 1'b0;
        end else begin
            o_word_valid <= commit;
            if (commit) begin
                o_word <= shift_next;
                case (addr)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: digits[digit_idx] <= data;
                    4'h9:    o_decode_mode  <= data;
                    4'hA:    o_intensity    <= data[3:0];
                    4'hB:    o_scan_limit   <= data[2:0];
                    4'hC:    o_shutdown_n   <= data[0];
                    4'hF:    o_display_test <= data[0];
                    default: ;
                endcase
            end
        end
    end

    assign o_rd_data = digits[i_rd_addr];

endmodule

// File: tb/tb_serial_display_receiver.sv
// Randomized self-checking bench for serial_display_receiver against a
// word-level reference model of the register file.
module tb_serial_display_receiver;

`ifdef SERIAL_RX_FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0, sclk = 1'b0, load = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [7:0]  rd_data, decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n, display_test, word_valid, frame_err;
    logic [15:0] word;

    int vectors = 0;
    int errors  = 0;

    // reference model state
    logic [15:0] mw;
    int          mcnt;
    logic [7:0]  mdig [8];
    logic [7:0]  mdec;
    logic [3:0]  mint;
    logic [2:0]  mscan;
    logic        mshdn, mtest;
    logic [15:0] mword;

    serial_display_receiver dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_serial_din(din),
        .i_serial_clk(sclk), .i_serial_load(load), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data), .o_decode_mode(decode_mode),
        .o_intensity(intensity), .o_scan_limit(scan_limit),
        .o_shutdown_n(shutdown_n), .o_display_test(display_test),
        .o_word_valid(word_valid), .o_word(word), .o_frame_err(frame_err)
    );

    always #50 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        mw = '0; mcnt = 0; mdec = '0; mint = '0; mscan = '0;
        mshdn = 1'b0; mtest = 1'b0; mword = '0;
        for (int i = 0; i < 8; i++) mdig[i] = '0;
    endtask

    task automatic shift_bit(input logic b);
        din = b;
        tick(4);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
        mw = {mw[14:0], b};
        mcnt = (mcnt < 31) ? mcnt + 1 : 31;
    endtask

    task automatic send_bits(input logic [31:0] value, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(value[i]);
        tick(4);
    endtask

    task automatic check_regs(input string tag);
        vectors++;
        if (word !== mword) begin errors++; $display("FAIL %s o_word got %h exp %h", tag, word, mword); end
        vectors++;
        if (decode_mode !== mdec) begin errors++; $display("FAIL %s decode_mode got %h exp %h", tag, decode_mode, mdec); end
        vectors++;
        if (intensity !== mint) begin errors++; $display("FAIL %s intensity got %h exp %h", tag, intensity, mint); end
        vectors++;
        if (scan_limit !== mscan) begin errors++; $display("FAIL %s scan_limit got %h exp %h", tag, scan_limit, mscan); end
        vectors++;
        if (shutdown_n !== mshdn) begin errors++; $display("FAIL %s shutdown_n got %b exp %b", tag, shutdown_n, mshdn); end
        vectors++;
        if (display_test !== mtest) begin errors++; $display("FAIL %s display_test got %b exp %b", tag, display_test, mtest); end
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            vectors++;
            if (rd_data !== mdig[a]) begin errors++; $display("FAIL %s rd_data[%0d] got %h exp %h", tag, a, rd_data, mdig[a]); end
        end
    endtask

    // Pulse load, watch a bounded window for the commit, then compare everything.
    task automatic do_load(input string tag);
        logic       ok;
        logic [3:0] a;
        logic [7:0] d;
        int         nvld, nerr;
        logic [7:0] rd_at_vld;
        logic [7:0] exp_rd;
        logic [3:0] int_at_vld;
        ok = FC ? (mcnt == 16) : 1'b1;
        a = mw[11:8];
        d = mw[7:0];
        if (ok) begin
            mword = mw;
            case (a)
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: mdig[a - 4'd1] = d;
                4'h9: mdec = d;
                4'hA: mint = d[3:0];
                4'hB: mscan = d[2:0];
                4'hC: mshdn = d[0];
                4'hF: mtest = d[0];
                default: ;
            endcase
        end
        mcnt = 0;
        rd_addr = (a >= 4'h1 && a <= 4'h8) ? 3'(a - 4'd1) : 3'($urandom_range(0, 7));
        exp_rd = mdig[rd_addr];
        nvld = 0; nerr = 0; rd_at_vld = 'x; int_at_vld = 'x;
        load = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (word_valid) begin nvld++; rd_at_vld = rd_data; int_at_vld = intensity; end
            if (frame_err) nerr++;
            if (c == 3) load = 1'b0;
        end
        vectors++;
        if (nvld !== (ok ? 1 : 0)) begin errors++; $display("FAIL %s valid_cycles got %0d exp %0d", tag, nvld, ok ? 1 : 0); end
        vectors++;
        if (nerr !== ((FC && !ok) ? 1 : 0)) begin errors++; $display("FAIL %s frame_err_cycles got %0d exp %0d", tag, nerr, (FC && !ok) ? 1 : 0); end
        if (ok) begin
            vectors++;
            if (rd_at_vld !== exp_rd) begin errors++; $display("FAIL %s rd_data_at_valid got %h exp %h", tag, rd_at_vld, exp_rd); end
            vectors++;
            if (int_at_vld !== mint) begin errors++; $display("FAIL %s intensity_at_valid got %h exp %h", tag, int_at_vld, mint); end
        end
        check_regs(tag);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; din = 1'b0; sclk = 1'b0; load = 1'b0;
        tick(3);
        model_reset();
        check_regs("reset_held");
        vectors++;
        if (word_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got vld=%b ferr=%b exp 0 0", word_valid, frame_err);
        end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_reset();
        apply_reset();
        check_regs("reset_release");
    endtask

    task automatic test_intensity();
        send_bits(32'h0A05, 16);
        do_load("intensity_0a05");
    endtask

    task automatic test_digit();
        send_bits(32'h0C01, 16);
        do_load("shutdown_0c01");
        send_bits(32'h0337, 16);
        do_load("digit3_0337");
        rd_addr = 3'd2;
        #1;
        vectors++;
        if (rd_data !== 8'h37) begin errors++; $display("FAIL digit_rd2 got %h exp 37", rd_data); end
        vectors++;
        if (shutdown_n !== 1'b1) begin errors++; $display("FAIL shutdown_on got %b exp 1", shutdown_n); end
    endtask

    task automatic test_overlong();
        send_bits(32'h50B07, 20);
        do_load("overlong_20bits");
    endtask

    task automatic test_short();
        send_bits(32'h1A3C, 15);
        do_load("short_15bits");
    endtask

    task automatic test_reset_mid();
        send_bits(32'hA5, 8);
        apply_reset();
        send_bits(32'h0F01, 16);
        do_load("after_midreset_0f01");
        vectors++;
        if (display_test !== 1'b1) begin errors++; $display("FAIL midreset_test got %b exp 1", display_test); end
    endtask

    task automatic test_noop();
        send_bits(32'h0DFF, 16);
        do_load("noop_0dff");
        send_bits(32'h30FF, 16);
        do_load("noop_addr0");
    endtask

    task automatic test_random(input int n);
        logic [31:0] v;
        int          nb;
        for (int i = 0; i < n; i++) begin
            v = $urandom;
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 20) : 16;
            send_bits(v, nb);
            do_load($sformatf("random_%0d", i));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_intensity();
        test_digit();
        test_overlong();
        test_short();
        test_noop();
        test_reset_mid();
        test_random(60);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/serial_display_receiver.md
SERIAL_DISPLAY_RECEIVER -- requirements
Module: serial_display_receiver

Interface
REQ-001 SHALL have port i_clk, input, 1: system clock (~10 MHz); all state on its rising edge.
REQ-002 SHALL have port i_reset_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port i_serial_din, input, 1: serial data, asynchronous to i_clk.
REQ-004 SHALL have port i_serial_clk, input, 1: serial shift clock, asynchronous to i_clk.
REQ-005 SHALL have port i_serial_load, input, 1: word latch strobe, asynchronous to i_clk.
REQ-006 SHALL have port i_rd_addr, input, 3: digit register read select (0 = digit 1 .. 7 = digit 8).
REQ-007 SHALL have port o_rd_data, output, 8: combinational read of selected digit register.
REQ-008 SHALL have port o_decode_mode, output, 8; o_intensity, output, 4; o_scan_limit, output, 3; o_shutdown_n, output, 1; o_display_test, output, 1.
REQ-009 SHALL have port o_word_valid, output, 1: one-cycle pulse per committed word; o_word, output, 16: last committed word.
REQ-010 SHALL have port o_frame_err, output, 1: one-cycle pulse on a rejected frame (feature per REQ-027).

Function
REQ-011 SHALL pass each serial input through a 2-flop synchronizer plus one history flop; rising edge = synced high and history low.
REQ-012 SHALL shift the synced din into a 16-bit shift register LSB, MSB-first order, one i_clk cycle after each detected serial_clk rising edge (3 i_clk from pin edge to shift).
REQ-013 SHALL require serial_clk and serial_load high/low phases of at least 3 i_clk periods; shorter pulses are unsupported.
REQ-014 SHALL count shifted bits in a 5-bit counter saturating at 31; counter clears on every load rising edge.
REQ-015 SHALL commit on detected load rising edge: o_word <= shift register, o_word_valid high for exactly one cycle.
REQ-016 SHALL decode committed word: address = bits[11:8], data = bits[7:0]; bits[15:12] ignored.
REQ-017 SHALL write address 0x1-0x8 to digit register (address-1); 0x9 -> o_decode_mode; 0xA -> o_intensity = data[3:0]; 0xB -> o_scan_limit = data[2:0]; 0xC -> o_shutdown_n = data[0]; 0xF -> o_display_test = data[0].
REQ-018 SHALL treat addresses 0x0, 0xD, 0xE as no-op: o_word_valid still pulses, no register changes.
REQ-019 SHALL, when clk and load rising edges are detected in the same cycle, apply the shift first and commit the post-shift value with the post-shift count.
REQ-020 SHALL allow more than 16 shifted bits; only the last 16 are retained (shift register wraps).
REQ-021 SHALL update register outputs in the same cycle o_word_valid is high; o_rd_data reflects new digit value that cycle.
REQ-022 SHALL hold all register outputs while no load edge occurs, regardless of serial_clk activity.

Reset
REQ-023 SHALL, while i_reset_n low, clear synchronizers, shift register, bit counter, o_word, all digit registers, o_decode_mode, o_intensity, o_scan_limit, o_display_test to 0.
REQ-024 SHALL reset o_shutdown_n to 0 (display shut down) and o_word_valid, o_frame_err to 0.
REQ-025 SHALL discard any partially shifted word when reset asserts mid-frame; first frame after release starts with count 0.
REQ-026 SHALL not detect a false edge on release when serial inputs are already high (history flops reset low, synchronizer fills before history: a high line yields at most one edge, which is treated as a real edge).

Configuration
REQ-027 SHALL support macro SERIAL_RX_FRAME_CHECK_EN: defined -> commit only if bit count == 16; otherwise no register/o_word update, no o_word_valid, o_frame_err pulses one cycle.
REQ-028 SHALL, without SERIAL_RX_FRAME_CHECK_EN, commit last 16 bits on every load edge regardless of count; o_frame_err tied 0.

Verification
REQ-029 SHALL cover: shift 0x0A05, pulse load -> o_word_valid one cycle, o_word=0x0A05, o_intensity=5.
REQ-030 SHALL cover: words 0x0C01 then 0x0337 -> o_shutdown_n=1; i_rd_addr=2 gives o_rd_data=0x37.
REQ-031 SHALL cover: 20 bits ending in 0x0B07 then load -> o_scan_limit=7 without macro; with macro o_frame_err pulse, o_scan_limit stays 0.
REQ-032 SHALL cover: 15 bits then load with macro defined -> o_frame_err=1 one cycle, o_word unchanged.
REQ-033 SHALL cover: i_reset_n low after 8 bits, release, send 0x0F01 -> o_display_test=1, bits before reset have no effect.
REQ-034 SHALL cover: word 0x0DFF -> o_word_valid pulse, all register outputs unchanged.
